// File: rtl/alu_seq.sv
// alu_seq: sequential RV integer ALU; single-cycle ALU/branch ops, iterative shift-add multiply.
// Define ALU_SEQ_DIV_EN to build the restoring divider (DIV/DIVU/REM/REMU); otherwise those are illegal.
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;

    localparam logic [1:0] K_MUL_LO = 2'd0;
    localparam logic [1:0] K_MUL_HI = 2'd1;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [1:0] K_DIV_Q  = 2'd2;
    localparam logic [1:0] K_DIV_R  = 2'd3;
`endif

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic            neg_q, neg_d;
    logic [1:0]      kind_q, kind_d;
`ifdef ALU_SEQ_DIV_EN
    logic            rneg_q, rneg_d;
    logic            dec_rneg;
    logic [XLEN:0]   rem_sh;
`endif

    logic [XLEN-1:0]   alu_res, dec_a, dec_b;
    logic              dec_ill, dec_iter, dec_neg, sa, sb, alt, accept;
    logic [1:0]        dec_kind;
    logic [SHW-1:0]    shamt;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   step_hi, step_lo, fin_res;
    logic [2*XLEN-1:0] prod;

    // Decode and single-cycle datapath, evaluated on the live request inputs.
    always_comb begin
        alu_res  = '0;
        dec_ill  = 1'b0;
        dec_iter = 1'b0;
        dec_kind = K_MUL_LO;
        sa       = 1'b0;
        sb       = 1'b0;
        alt      = (funct7 == 7'h20);
        shamt    = op_b[SHW-1:0];
        case (opcode)
            OPC_LOAD, OPC_STORE, OPC_AUIPC: alu_res = op_a + op_b;
            OPC_BRANCH: begin
                case (funct3)
                    3'd0:    alu_res[0] = (op_a == op_b);
                    3'd1:    alu_res[0] = (op_a != op_b);
                    3'd4:    alu_res[0] = ($signed(op_a) < $signed(op_b));
                    3'd5:    alu_res[0] = ($signed(op_a) >= $signed(op_b));
                    3'd6:    alu_res[0] = (op_a < op_b);
                    3'd7:    alu_res[0] = (op_a >= op_b);
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_OP, OPC_OPIMM: begin
                if (opcode == OPC_OP && funct7 == 7'h01) begin
                    dec_iter = 1'b1;
                    case (funct3)
                        3'd0: dec_kind = K_MUL_LO;
                        3'd1: begin dec_kind = K_MUL_HI; sa = op_a[XLEN-1]; sb = op_b[XLEN-1]; end
                        3'd2: begin dec_kind = K_MUL_HI; sa = op_a[XLEN-1]; end
                        3'd3: dec_kind = K_MUL_HI;
`ifdef ALU_SEQ_DIV_EN
                        3'd4: begin dec_kind = K_DIV_Q; sa = op_a[XLEN-1]; sb = op_b[XLEN-1]; end
                        3'd5: dec_kind = K_DIV_Q;
                        3'd6: begin dec_kind = K_DIV_R; sa = op_a[XLEN-1]; sb = op_b[XLEN-1]; end
                        3'd7: dec_kind = K_DIV_R;
`endif
                        default: begin dec_ill = 1'b1; dec_iter = 1'b0; end
                    endcase
                end else begin
                    if (opcode == OPC_OP)
                        dec_ill = !((funct7 == 7'h00) || (alt && (funct3 == 3'd0 || funct3 == 3'd5)));
                    else if (funct3 == 3'd1)
                        dec_ill = (funct7 != 7'h00);
                    else if (funct3 == 3'd5)
                        dec_ill = !((funct7 == 7'h00) || alt);
                    case (funct3)
                        3'd0: alu_res = (opcode == OPC_OP && alt) ? op_a - op_b : op_a + op_b;
                        3'd1: alu_res = op_a << shamt;
                        3'd2: alu_res[0] = ($signed(op_a) < $signed(op_b));
                        3'd3: alu_res[0] = (op_a < op_b);
                        3'd4: alu_res = op_a ^ op_b;
                        3'd5: begin
                            if (alt) alu_res = $signed(op_a) >>> shamt;
                            else     alu_res = op_a >> shamt;
                        end
                        3'd6: alu_res = op_a | op_b;
                        default: alu_res = op_a & op_b;
                    endcase
                end
            end
            default: dec_ill = 1'b1;
        endcase
        // Iterative ops run on magnitudes; the sign is reapplied when they finish.
        dec_a   = sa ? -op_a : op_a;
        dec_b   = sb ? -op_b : op_b;
        dec_neg = sa ^ sb;
`ifdef ALU_SEQ_DIV_EN
        dec_rneg = sa;
        if (dec_kind[1] && op_b == '0) dec_neg = 1'b0;
`endif
    end

    // One multiply (or divide) step per BUSY cycle; hi_q:lo_q is the working pair.
    always_comb begin
        mul_sum = {1'b0, hi_q} + {1'b0, {XLEN{lo_q[0]}} & opnd_q};
        step_hi = mul_sum[XLEN:1];
        step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
`ifdef ALU_SEQ_DIV_EN
        rem_sh = {hi_q, lo_q[XLEN-1]};
        if (kind_q[1]) begin
            if (rem_sh >= {1'b0, opnd_q}) begin
                step_hi = rem_sh[XLEN-1:0] - opnd_q;
                step_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi = rem_sh[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end
`endif
        prod = {step_hi, step_lo};
        if (neg_q) prod = -prod;
        case (kind_q)
            K_MUL_LO: fin_res = prod[XLEN-1:0];
            K_MUL_HI: fin_res = prod[2*XLEN-1:XLEN];
`ifdef ALU_SEQ_DIV_EN
            K_DIV_Q:  fin_res = neg_q ? -step_lo : step_lo;
            default:  fin_res = rneg_q ? -step_hi : step_hi;
`else
            default:  fin_res = '0;
`endif
        endcase
    end

    assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        kind_d    = kind_q;
`ifdef ALU_SEQ_DIV_EN
        rneg_d    = rneg_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (dec_iter) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = dec_a;
                        opnd_d  = dec_b;
                        neg_d   = dec_neg;
                        kind_d  = dec_kind;
`ifdef ALU_SEQ_DIV_EN
                        rneg_d  = dec_rneg;
`endif
                    end else begin
                        state_d   = DONE;
                        result_d  = dec_ill ? '0 : alu_res;
                        illegal_d = dec_ill;
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(XLEN - 1)) begin
                    state_d   = DONE;
                    result_d  = fin_res;
                    illegal_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            kind_q    <= K_MUL_LO;
`ifdef ALU_SEQ_DIV_EN
            rneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            kind_q    <= kind_d;
`ifdef ALU_SEQ_DIV_EN
            rneg_q    <= rneg_d;
`endif
        end
    end

    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (XLEN=32); divide checks follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
    localparam int XLEN = 32;
    localparam int ITER_LAT = XLEN + 1;
    localparam logic [6:0] OPC_LOAD = 7'h03, OPC_STORE = 7'h23, OPC_AUIPC = 7'h17;
    localparam logic [6:0] OPC_BRANCH = 7'h63, OPC_OP = 7'h33, OPC_OPIMM = 7'h13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        illegal;

    alu_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
        string       name;
    } exp_t;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        string       name;
    } vec_t;

    exp_t exp_q[$];
    vec_t vec_q[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] mul_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f3)
            3'd0:    begin p = ua * ub; return p[31:0];  end
            3'd1:    begin p = sa * sb; return p[63:32]; end
            3'd2:    begin p = sa * ub; return p[63:32]; end
            default: begin p = ua * ub; return p[63:32]; end
        endcase
    endfunction

    function automatic logic [31:0] div_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drive one request, push its expectation, return just after the accepting edge.
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                        input logic ei, input int elat, input string nm);
        exp_t e;
        int n = 0;
        opcode = opc; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept_timeout in_ready=%b required=1", nm, in_ready);
        end
        e.res = er; e.ill = ei; e.lat = elat; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic add_vec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                           input logic ill, input string nm);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.res = r; v.ill = ill; v.name = nm;
        vec_q.push_back(v);
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_state out_valid=%b result=%h illegal=%b required 0/0/0", out_valid, result, illegal);
        end
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b required=1", in_ready);
        end
        $display("txn reset released in_ready=%b", in_ready);
    endtask

    task automatic test_alu_ops;
        int lat;
        exp_t e;
        vec_q.delete();
        add_vec(OPC_OP,     3'd0, 7'h00, 32'd5,        32'd7,        32'd12,         1'b0, "add");
        add_vec(OPC_OP,     3'd0, 7'h20, 32'd5,        32'd7,        32'hFFFF_FFFE,  1'b0, "sub");
        add_vec(OPC_OP,     3'd1, 7'h00, 32'd1,        32'h23,       32'd8,          1'b0, "sll_lowbits");
        add_vec(OPC_OP,     3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1,       32'd1,          1'b0, "slt");
        add_vec(OPC_OP,     3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1,       32'd0,          1'b0, "sltu");
        add_vec(OPC_OP,     3'd4, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, "xor");
        add_vec(OPC_OP,     3'd5, 7'h00, 32'h8000_0000, 32'd4,       32'h0800_0000,  1'b0, "srl");
        add_vec(OPC_OP,     3'd5, 7'h20, 32'h8000_0000, 32'd4,       32'hF800_0000,  1'b0, "sra");
        add_vec(OPC_OP,     3'd6, 7'h00, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1'b0, "or");
        add_vec(OPC_OP,     3'd7, 7'h00, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, "and");
        add_vec(OPC_OPIMM,  3'd5, 7'h20, 32'hFFFF_FF00, 32'h404,     32'hFFFF_FFF0,  1'b0, "srai");
        add_vec(OPC_OPIMM,  3'd1, 7'h20, 32'd1,        32'd1,        32'd0,          1'b1, "slli_bad_f7");
        add_vec(OPC_OPIMM,  3'd0, 7'h20, 32'd10,       32'hFFFF_FFFF, 32'd9,         1'b0, "addi");
        add_vec(OPC_LOAD,   3'd2, 7'h00, 32'h1000,     32'h24,       32'h1024,       1'b0, "load");
        add_vec(OPC_STORE,  3'd2, 7'h00, 32'd8,        32'hFFFF_FFFC, 32'd4,         1'b0, "store");
        add_vec(OPC_AUIPC,  3'd0, 7'h00, 32'h8000_0000, 32'h1000,    32'h8000_1000,  1'b0, "auipc");
        add_vec(7'h7F,      3'd0, 7'h00, 32'd1,        32'd1,        32'd0,          1'b1, "bad_opcode");
        add_vec(OPC_OP,     3'd0, 7'h40, 32'd1,        32'd1,        32'd0,          1'b1, "op_bad_f7");
        add_vec(OPC_OP,     3'd4, 7'h20, 32'd1,        32'd1,        32'd0,          1'b1, "op_f7_20_xor");
        add_vec(OPC_BRANCH, 3'd3, 7'h00, 32'd1,        32'd1,        32'd0,          1'b1, "branch_f3_3");
        add_vec(OPC_BRANCH, 3'd4, 7'h00, 32'hFFFF_FFFF, 32'd1,       32'd1,          1'b0, "blt");
        add_vec(OPC_BRANCH, 3'd0, 7'h00, 32'd7,        32'd7,        32'd1,          1'b0, "beq");
        add_vec(OPC_BRANCH, 3'd1, 7'h00, 32'd7,        32'd7,        32'd0,          1'b0, "bne");
        add_vec(OPC_BRANCH, 3'd5, 7'h00, 32'hFFFF_FFFF, 32'd1,       32'd0,          1'b0, "bge");
        add_vec(OPC_BRANCH, 3'd6, 7'h00, 32'hFFFF_FFFF, 32'd1,       32'd0,          1'b0, "bltu");
        add_vec(OPC_BRANCH, 3'd7, 7'h00, 32'hFFFF_FFFF, 32'd1,       32'd1,          1'b0, "bgeu");
        out_ready = 1'b1;
        foreach (vec_q[i]) begin
            send(vec_q[i].opc, vec_q[i].f3, vec_q[i].f7, vec_q[i].a, vec_q[i].b,
                 vec_q[i].res, vec_q[i].ill, 1, vec_q[i].name);
            wait_out(lat);
            e = exp_q.pop_front();
            checks++;
            if (lat != e.lat || result !== e.res || illegal !== e.ill) begin
                failures++;
                $display("FAIL %s got res=%h ill=%b lat=%0d required res=%h ill=%b lat=%0d",
                         e.name, result, illegal, lat, e.res, e.ill, e.lat);
            end
            $display("txn %s result=%h illegal=%b lat=%0d", e.name, result, illegal, lat);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mul;
        int lat;
        exp_t e;
        logic [31:0] a, b;
        logic [2:0] f3;
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            f3 = 3'(i % 4);
            case (i / 4)
                0: begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
                1: begin a = 32'h8000_0000; b = (i % 2 == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            send(OPC_OP, f3, 7'h01, a, b, mul_model(f3, a, b), 1'b0, ITER_LAT, "mul");
            op_a = ~a;
            op_b = b ^ 32'h5A5A_5A5A;
            opcode = OPC_OP; funct3 = 3'd0; funct7 = 7'h20;
            wait_out(lat);
            e = exp_q.pop_front();
            checks++;
            if (lat != e.lat || result !== e.res || illegal !== e.ill) begin
                failures++;
                $display("FAIL mul f3=%0d a=%h b=%h got res=%h ill=%b lat=%0d required res=%h ill=%b lat=%0d",
                         f3, a, b, result, illegal, lat, e.res, e.ill, e.lat);
            end
            $display("txn mul f3=%0d a=%h b=%h result=%h lat=%0d", f3, a, b, result, lat);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mulhu_stall;
        int lat;
        exp_t e;
        out_ready = 1'b0;
        send(OPC_OP, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, ITER_LAT, "mulhu_stall");
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat != e.lat || result !== e.res || illegal !== e.ill) begin
            failures++;
            $display("FAIL mulhu_stall got res=%h lat=%0d required res=%h lat=%0d", result, lat, e.res, e.lat);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE || illegal !== 1'b0) begin
                failures++;
                $display("FAIL mulhu_hold%0d got valid=%b res=%h required valid=1 res=fffffffe", i, out_valid, result);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mulhu_release got valid=%b required=0", out_valid);
        end
        $display("txn mulhu_stall result=%h lat=%0d", e.res, lat);
    endtask

    task automatic test_div;
        int lat;
        exp_t e;
        logic [31:0] av[10];
        logic [31:0] bv[10];
        logic [2:0]  fv[10];
        av = '{32'h8000_0000, 32'd9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd7, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0, 32'd0};
        bv = '{32'hFFFF_FFFF, 32'd0, 32'd2,         32'd2,         32'd7,   32'd0, 32'd0,         32'hFFFF_FFFF, 32'd0, 32'd0};
        fv = '{3'd4,          3'd7,  3'd4,          3'd6,          3'd5,    3'd6,  3'd4,          3'd6,          3'd5,  3'd7};
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            logic [31:0] a, b, er;
            logic [2:0] f3;
            logic ei;
            int el;
            if (i < 10) begin a = av[i]; b = bv[i]; f3 = fv[i]; end
            else begin a = $urandom; b = $urandom_range(1, 1000); f3 = 3'(4 + i % 4); end
`ifdef ALU_SEQ_DIV_EN
            er = div_model(f3, a, b); ei = 1'b0; el = ITER_LAT;
`else
            er = 32'h0; ei = 1'b1; el = 1;
`endif
            send(OPC_OP, f3, 7'h01, a, b, er, ei, el, "div");
            wait_out(lat);
            e = exp_q.pop_front();
            checks++;
            if (lat != e.lat || result !== e.res || illegal !== e.ill) begin
                failures++;
                $display("FAIL div f3=%0d a=%h b=%h got res=%h ill=%b lat=%0d required res=%h ill=%b lat=%0d",
                         f3, a, b, result, illegal, lat, e.res, e.ill, e.lat);
            end
            $display("txn div f3=%0d a=%h b=%h result=%h illegal=%b lat=%0d", f3, a, b, result, illegal, lat);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_mul;
        int lat;
        exp_t e;
        out_ready = 1'b1;
        send(OPC_OP, 3'd0, 7'h00, 32'h10, 32'h20, 32'h30, 1'b0, 1, "pre_add");
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (result !== e.res || lat != e.lat) begin
            failures++;
            $display("FAIL pre_add got res=%h lat=%0d required res=%h lat=%0d", result, lat, e.res, e.lat);
        end
        @(posedge clk); #1;
        send(OPC_OP, 3'd0, 7'h01, 32'd3, 32'd5, 32'd15, 1'b0, ITER_LAT, "mul_aborted");
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL mid_mul_reset got valid=%b res=%h ill=%b required 0/0/0", out_valid, result, illegal);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got in_ready=%b valid=%b required 1/0", in_ready, out_valid);
        end
        send(OPC_OP, 3'd0, 7'h00, 32'd2, 32'd3, 32'd5, 1'b0, 1, "add_after_reset");
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat != e.lat || result !== e.res || illegal !== e.ill) begin
            failures++;
            $display("FAIL add_after_reset got res=%h lat=%0d required res=%h lat=%0d", result, lat, e.res, e.lat);
        end
        $display("txn add_after_reset result=%h lat=%0d", result, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        out_ready = 1'b1;
        opcode = OPC_OP; funct3 = 3'd0; funct7 = 7'h00; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_a = 32'h100 * (i + 1);
            op_b = 32'(i + 7);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_in_ready%0d got=%b required=1", i, in_ready);
            end
            e.res = op_a + op_b; e.ill = 1'b0; e.lat = 1; e.name = "b2b";
            exp_q.push_back(e);
            @(posedge clk); #1;
            if (i == 3) in_valid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || result !== e.res || illegal !== 1'b0) begin
                failures++;
                $display("FAIL b2b%0d got valid=%b res=%h required valid=1 res=%h", i, out_valid, result, e.res);
            end
            $display("txn b2b%0d result=%h", i, result);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got valid=%b required=0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mul();
        test_mulhu_stall();
        test_div();
        test_reset_mid_mul();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
